// File: rtl/block_word_arbiter_pkg.sv
// Shared definitions for the word arbiter: arbiter FSM encoding, word/block
// geometry and the big-endian word append used by the block builder.
package block_word_arbiter_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_PAD  = 2'd2
  } arb_state_t;

  // Oldest word ends up in the top slice once four words have been appended.
  function automatic logic [BLOCK_W-1:0] append_word(
    input logic [BLOCK_W-1:0] acc,
    input logic [WORD_W-1:0]  w
  );
    return {acc[BLOCK_W-WORD_W-1:0], w};
  endfunction

endpackage

// File: rtl/block_word_arbiter_builder.sv
// Big-endian word-to-block builder: one output block register plus one
// filling buffer, so a complete block can wait behind a stalled output.
module be_block_builder
  import block_word_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               word_valid,
  output logic               word_ready,
  input  logic [WORD_W-1:0]  word,
  output logic               block_valid,
  input  logic               block_ready,
  output logic [BLOCK_W-1:0] block
);

  localparam logic [2:0] CNT_LAST = 3'(WORDS_PER_BLOCK - 1);
  localparam logic [2:0] CNT_FULL = 3'(WORDS_PER_BLOCK);

  logic [2:0]         fill_cnt_p0;
  logic [BLOCK_W-1:0] fill_buf_p0;
  logic               vld_p1;
  logic [BLOCK_W-1:0] blk_p1;

  logic xfer;
  logic out_free;
  logic fill_full;
  logic last_word;

  assign fill_full   = (fill_cnt_p0 == CNT_FULL);
  assign word_ready  = !fill_full;
  assign xfer        = word_valid && word_ready;
  assign out_free    = !vld_p1 || block_ready;
  assign last_word   = xfer && (fill_cnt_p0 == CNT_LAST);
  assign block_valid = vld_p1;
  assign block       = blk_p1;

  // Fill stage (p0): accumulate words; a completed block bypasses straight
  // to the output register when it is free, otherwise it parks here.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_p0 <= 3'd0;
    end else if (fill_full) begin
      if (out_free) fill_cnt_p0 <= 3'd0;
    end else if (xfer) begin
      fill_cnt_p0 <= (last_word && out_free) ? 3'd0 : fill_cnt_p0 + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) fill_buf_p0 <= append_word(fill_buf_p0, word);
  end

  // Output stage (p1)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (out_free) begin
      vld_p1 <= fill_full || last_word;
    end
  end

  always_ff @(posedge clk) begin
    if (out_free) begin
      if (fill_full)      blk_p1 <= fill_buf_p0;
      else if (last_word) blk_p1 <= append_word(fill_buf_p0, word);
    end
  end

endmodule

// File: rtl/block_word_arbiter.sv
// Round-robin arbiter gathering 32-bit words from several requesters into
// 128-bit blocks, zero-padding short messages and tagging each block.
module block_word_arbiter
  import block_word_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [WORD_W*NUM_REQ-1:0] req_word,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic                      block_valid,
  input  logic                      block_ready,
  output logic [BLOCK_W-1:0]        block,
  output logic [OWN_W-1:0]          block_owner,
  output logic                      block_last
);

  arb_state_t       state_q;
  logic [OWN_W-1:0] grant_q;
  logic [OWN_W-1:0] rr_ptr_q;
  logic [1:0]       word_cnt_q;

  logic              sel_valid;
  logic              sel_last;
  logic [WORD_W-1:0] sel_word;
  logic              found;
  logic [OWN_W-1:0]  found_idx;
  logic [OWN_W:0]    cand;

  logic              bld_word_valid;
  logic              bld_word_ready;
  logic [WORD_W-1:0] bld_word;
  logic              bld_xfer;
  logic              blk_done;

  logic [OWN_W-1:0] tag_own_q [2];
  logic             tag_last_q [2];
  logic             tag_wr_q;
  logic             tag_rd_q;
  logic [1:0]       tag_cnt_q;
  logic             tag_push;
  logic             tag_push_last;
  logic             tag_pop;

  function automatic logic [OWN_W-1:0] next_idx(input logic [OWN_W-1:0] i);
    return (i == OWN_W'(NUM_REQ - 1)) ? '0 : i + OWN_W'(1);
  endfunction

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_word  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == OWN_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_word  = req_word[i*WORD_W +: WORD_W];
      end
    end
  end

  // Rotate the search so it starts just past the previous winner.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (OWN_W+1)'(k);
      if (cand >= (OWN_W+1)'(NUM_REQ)) cand = cand - (OWN_W+1)'(NUM_REQ);
      if (!found && req_valid[cand[OWN_W-1:0]]) begin
        found     = 1'b1;
        found_idx = cand[OWN_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_PASS) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q == OWN_W'(i)) req_ready[i] = bld_word_ready;
      end
    end
  end

  assign bld_word_valid = ((state_q == ST_PASS) && sel_valid) || (state_q == ST_PAD);
  assign bld_word       = (state_q == ST_PASS) ? sel_word : '0;
  assign bld_xfer       = bld_word_valid && bld_word_ready;
  assign blk_done       = bld_xfer && (word_cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      word_cnt_q <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          word_cnt_q <= 2'd0;
          if (found) begin
            grant_q  <= found_idx;
            rr_ptr_q <= next_idx(found_idx);
            state_q  <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (bld_xfer) begin
            word_cnt_q <= word_cnt_q + 2'd1;
            if (word_cnt_q == 2'd3) state_q <= ST_IDLE;
            else if (sel_last)      state_q <= ST_PAD;
          end
        end
        ST_PAD: begin
          if (bld_xfer) begin
            word_cnt_q <= word_cnt_q + 2'd1;
            if (word_cnt_q == 2'd3) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  be_block_builder u_builder (
    .clk         (clk),
    .rst         (rst),
    .word_valid  (bld_word_valid),
    .word_ready  (bld_word_ready),
    .word        (bld_word),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block       (block)
  );

  // Tag FIFO mirrors the builder's two block slots, so it cannot overflow.
  assign tag_push      = blk_done;
  assign tag_push_last = (state_q == ST_PAD) ? 1'b1 : sel_last;
  assign tag_pop       = block_valid && block_ready && (tag_cnt_q != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr_q  <= 1'b0;
      tag_rd_q  <= 1'b0;
      tag_cnt_q <= 2'd0;
    end else begin
      if (tag_push) tag_wr_q <= !tag_wr_q;
      if (tag_pop)  tag_rd_q <= !tag_rd_q;
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt_q <= tag_cnt_q + 2'd1;
        2'b01:   tag_cnt_q <= tag_cnt_q - 2'd1;
        default: tag_cnt_q <= tag_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_own_q[tag_wr_q]  <= grant_q;
      tag_last_q[tag_wr_q] <= tag_push_last;
    end
  end

  assign block_owner = (tag_cnt_q != 2'd0) ? tag_own_q[tag_rd_q]  : '0;
  assign block_last  = (tag_cnt_q != 2'd0) ? tag_last_q[tag_rd_q] : 1'b0;

endmodule

// File: tb/tb_block_word_arbiter.sv
// Directed bench for block_word_arbiter with two requesters.
module tb_block_word_arbiter;

  localparam int NUM_REQ = 2;
  localparam int OWN_W   = 1;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [32*NUM_REQ-1:0] req_word;
  logic [NUM_REQ-1:0]   req_last;
  logic                 block_valid;
  logic                 block_ready;
  logic [127:0]         block;
  logic [OWN_W-1:0]     block_owner;
  logic                 block_last;

  int total;
  int bad;

  logic [127:0]     blk_q[$];
  logic [OWN_W-1:0] own_q[$];
  logic             last_q[$];

  block_word_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_word    (req_word),
    .req_last    (req_last),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block       (block),
    .block_owner (block_owner),
    .block_last  (block_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Blocks accepted at the next rising edge are logged mid-cycle.
  always @(negedge clk) begin
    if (!rst && block_valid && block_ready) begin
      blk_q.push_back(block);
      own_q.push_back(block_owner);
      last_q.push_back(block_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    blk_q.delete();
    own_q.delete();
    last_q.delete();
  endtask

  task automatic send_word(input int r, input logic [31:0] w, input logic l);
    int budget;
    req_valid[r] = 1'b1;
    req_word[r*32 +: 32] = w;
    req_last[r] = l;
    budget = 50;
    while (!req_ready[r] && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      total++; bad++;
      $display("FAIL send_timeout r=%0d got req_ready=0 want 1", r);
    end
    tick();
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic wait_blocks(input int n);
    int budget;
    budget = 200;
    while (blk_q.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    total++;
    if (blk_q.size() < n) begin
      bad++;
      $display("FAIL wait_blocks got=%0d want=%0d", blk_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (req_ready !== 2'b00 || block_valid !== 1'b0) begin
      bad++; $display("FAIL reset_in got ready=%b bv=%b want 00 0", req_ready, block_valid);
    end
    total++;
    if (block_owner !== 1'b0 || block_last !== 1'b0) begin
      bad++; $display("FAIL reset_tag got own=%b last=%b want 0 0", block_owner, block_last);
    end
    rst = 1'b0;
    tick();
    total++;
    if (req_ready !== 2'b00 || block_valid !== 1'b0 || block_owner !== 1'b0 || block_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_after got ready=%b bv=%b own=%b last=%b want 00 0 0 0",
               req_ready, block_valid, block_owner, block_last);
    end
  endtask

  task automatic test_single();
    clear_log();
    block_ready = 1'b1;
    send_word(0, 32'h01234567, 1'b0);
    send_word(0, 32'h89ABCDEF, 1'b0);
    send_word(0, 32'hA0A0A0A0, 1'b0);
    send_word(0, 32'hF9F9F9F9, 1'b0);
    total++;
    if (block_valid !== 1'b1) begin
      bad++; $display("FAIL single_latency got bv=%b want 1", block_valid);
    end
    wait_blocks(1);
    total++;
    if (blk_q.size() < 1 || blk_q[0] !== 128'h0123456789ABCDEFA0A0A0A0F9F9F9F9
        || own_q[0] !== 1'b0 || last_q[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_block got %h own=%b last=%b want 0123456789abcdefa0a0a0a0f9f9f9f9 own=0 last=0",
               (blk_q.size() > 0) ? blk_q[0] : 128'hx, (own_q.size() > 0) ? own_q[0] : 1'bx,
               (last_q.size() > 0) ? last_q[0] : 1'bx);
    end
  endtask

  task automatic test_padding();
    clear_log();
    send_word(1, 32'h11111111, 1'b0);
    send_word(1, 32'h22222222, 1'b1);
    total++;
    if (req_ready !== 2'b00 || block_valid !== 1'b0) begin
      bad++; $display("FAIL pad_cycle1 got ready=%b bv=%b want 00 0", req_ready, block_valid);
    end
    tick();
    total++;
    if (req_ready !== 2'b00 || block_valid !== 1'b0) begin
      bad++; $display("FAIL pad_cycle2 got ready=%b bv=%b want 00 0", req_ready, block_valid);
    end
    tick();
    total++;
    if (block_valid !== 1'b1 || block_owner !== 1'b1 || block_last !== 1'b1) begin
      bad++;
      $display("FAIL pad_done got bv=%b own=%b last=%b want 1 1 1", block_valid, block_owner, block_last);
    end
    wait_blocks(1);
    total++;
    if (blk_q.size() < 1 || blk_q[0] !== 128'h11111111222222220000000000000000) begin
      bad++;
      $display("FAIL pad_block got %h want 11111111222222220000000000000000",
               (blk_q.size() > 0) ? blk_q[0] : 128'hx);
    end
  endtask

  task automatic test_fairness();
    int sent0;
    int sent1;
    int budget;
    logic [1:0] hits;
    clear_log();
    sent0 = 0;
    sent1 = 0;
    budget = 300;
    req_word = {32'hC1C1C1C1, 32'hC0C0C0C0};
    while ((sent0 < 12 || sent1 < 12) && budget > 0) begin
      req_valid = {(sent1 < 12), (sent0 < 12)};
      hits = req_valid & req_ready;
      tick();
      if (hits[0]) sent0++;
      if (hits[1]) sent1++;
      budget--;
    end
    req_valid = 2'b00;
    total++;
    if (sent0 != 12 || sent1 != 12) begin
      bad++; $display("FAIL fair_words got %0d/%0d want 12/12", sent0, sent1);
    end
    wait_blocks(6);
    for (int i = 0; i < 6; i++) begin
      logic             exp_own;
      logic [127:0]     exp_blk;
      exp_own = i[0];
      exp_blk = exp_own ? {4{32'hC1C1C1C1}} : {4{32'hC0C0C0C0}};
      total++;
      if (blk_q.size() <= i || own_q[i] !== exp_own || blk_q[i] !== exp_blk) begin
        bad++;
        $display("FAIL fair_block%0d got own=%b blk=%h want own=%b blk=%h", i,
                 (own_q.size() > i) ? own_q[i] : 1'bx, (blk_q.size() > i) ? blk_q[i] : 128'hx,
                 exp_own, exp_blk);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    block_ready = 1'b0;
    for (int k = 1; k <= 8; k++) send_word(0, 32'h10000000 + k, 1'b0);
    req_valid[0] = 1'b1;
    req_word[31:0] = 32'hDEADBEEF;
    tick();
    total++;
    if (req_ready[0] !== 1'b0) begin
      bad++; $display("FAIL bp_stall1 got ready=%b want 0", req_ready[0]);
    end
    tick();
    total++;
    if (req_ready[0] !== 1'b0 || block_valid !== 1'b1 || block_owner !== 1'b0) begin
      bad++;
      $display("FAIL bp_stall2 got ready=%b bv=%b own=%b want 0 1 0", req_ready[0], block_valid, block_owner);
    end
    req_valid[0] = 1'b0;
    block_ready = 1'b1;
    wait_blocks(2);
    total++;
    if (blk_q.size() < 2 || blk_q[0] !== 128'h10000001100000021000000310000004
        || own_q[0] !== 1'b0 || last_q[0] !== 1'b0) begin
      bad++;
      $display("FAIL bp_block0 got %h want 10000001100000021000000310000004",
               (blk_q.size() > 0) ? blk_q[0] : 128'hx);
    end
    total++;
    if (blk_q.size() < 2 || blk_q[1] !== 128'h10000005100000061000000710000008
        || own_q[1] !== 1'b0 || last_q[1] !== 1'b0) begin
      bad++;
      $display("FAIL bp_block1 got %h want 10000005100000061000000710000008",
               (blk_q.size() > 1) ? blk_q[1] : 128'hx);
    end
  endtask

  task automatic test_reset_mid_block();
    clear_log();
    send_word(0, 32'hEEEE0001, 1'b0);
    send_word(0, 32'hEEEE0002, 1'b0);
    rst = 1'b1;
    tick();
    total++;
    if (req_ready !== 2'b00 || block_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_in got ready=%b bv=%b want 00 0", req_ready, block_valid);
    end
    rst = 1'b0;
    tick();
    total++;
    if (block_valid !== 1'b0 || block_owner !== 1'b0 || blk_q.size() != 0) begin
      bad++;
      $display("FAIL rstmid_after got bv=%b own=%b blocks=%0d want 0 0 0", block_valid, block_owner, blk_q.size());
    end
    send_word(1, 32'hB0000001, 1'b0);
    send_word(1, 32'hB0000002, 1'b0);
    send_word(1, 32'hB0000003, 1'b0);
    send_word(1, 32'hB0000004, 1'b0);
    wait_blocks(1);
    for (int k = 0; k < 5; k++) tick();
    total++;
    if (blk_q.size() != 1 || blk_q[0] !== 128'hB0000001B0000002B0000003B0000004
        || own_q[0] !== 1'b1 || last_q[0] !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_block got n=%0d %h own=%b want n=1 b0000001b0000002b0000003b0000004 own=1",
               blk_q.size(), (blk_q.size() > 0) ? blk_q[0] : 128'hx, (own_q.size() > 0) ? own_q[0] : 1'bx);
    end
  endtask

  task automatic test_last_on_fourth();
    clear_log();
    send_word(0, 32'h55550001, 1'b0);
    send_word(0, 32'h55550002, 1'b0);
    send_word(0, 32'h55550003, 1'b0);
    send_word(0, 32'h55550004, 1'b1);
    total++;
    if (block_valid !== 1'b1 || block_last !== 1'b1 || block_owner !== 1'b0) begin
      bad++;
      $display("FAIL last4_tag got bv=%b last=%b own=%b want 1 1 0", block_valid, block_last, block_owner);
    end
    req_valid[0] = 1'b1;
    req_word[31:0] = 32'h66660001;
    total++;
    if (req_ready[0] !== 1'b0) begin
      bad++; $display("FAIL last4_idle got ready=%b want 0", req_ready[0]);
    end
    tick();
    total++;
    if (req_ready[0] !== 1'b1) begin
      bad++; $display("FAIL last4_regrant got ready=%b want 1", req_ready[0]);
    end
    req_valid[0] = 1'b0;
    wait_blocks(1);
    total++;
    if (blk_q.size() < 1 || blk_q[0] !== 128'h55550001555500025555000355550004 || last_q[0] !== 1'b1) begin
      bad++;
      $display("FAIL last4_block got %h last=%b want 55550001555500025555000355550004 last=1",
               (blk_q.size() > 0) ? blk_q[0] : 128'hx, (last_q.size() > 0) ? last_q[0] : 1'bx);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    req_valid   = '0;
    req_word    = '0;
    req_last    = '0;
    block_ready = 1'b1;
    test_reset();
    test_single();
    test_padding();
    test_fairness();
    test_backpressure();
    test_reset_mid_block();
    test_last_on_fourth();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/block_word_arbiter.md
BLOCK_WORD_ARBITER -- requirements
Module: block_word_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of word requesters (2..4).
REQ-002 SHALL have parameter OWN_W, default $clog2(NUM_REQ), owner tag width.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester word valid.
REQ-006 SHALL have port req_ready  output  NUM_REQ  per-requester word ready.
REQ-007 SHALL have port req_word  input  32*NUM_REQ  word of requester i in bits [32i+31:32i].
REQ-008 SHALL have port req_last  input  NUM_REQ  word is final word of requester's message.
REQ-009 SHALL have port block_valid  output  1  assembled 128-bit block available.
REQ-010 SHALL have port block_ready  input  1  downstream accepts block.
REQ-011 SHALL have port block  output  128  big-endian block, first word in [127:96].
REQ-012 SHALL have port block_owner  output  OWN_W  requester index that produced block.
REQ-013 SHALL have port block_last  output  1  block terminated that requester's message.

Function
REQ-014 SHALL be a three-state FSM: IDLE (arbitrate), PASS (forward granted requester's words), PAD (inject zero words).
REQ-015 SHALL, in IDLE, register a grant to the first requester with req_valid high, searching round-robin from the index after the last granted one (index 0 first after reset), and enter PASS next cycle; req_ready all low in IDLE.
REQ-016 SHALL, in PASS, drive req_ready[g] = builder word_ready and all other req_ready low; a word transfers when req_valid[g] && req_ready[g].
REQ-017 SHALL count transferred words per block with a 2-bit counter (0..3), wrapping to 0 on the 4th word.
REQ-018 SHALL, on the 4th word of a block, push tag {g, req_last[g]} into the tag FIFO and return to IDLE, regardless of req_last.
REQ-019 SHALL, on a word with req_last high and count < 3, enter PAD; PAD drives word 32'h0 with valid high to the builder until the 4th word transfers, then pushes tag {g, 1} and returns to IDLE.
REQ-020 SHALL hold the grant for a whole block; blocks from different requesters never interleave.
REQ-021 SHALL keep a 2-entry tag FIFO: pushed at block completion, popped on block_valid && block_ready; block_owner/block_last come from the FIFO head.
REQ-022 SHALL, on simultaneous push and pop, keep occupancy unchanged; FIFO never overflows because the builder deasserts word_ready while holding a full block plus a filling one.
REQ-023 SHALL pass block_valid/block/block_ready straight through from the builder; word-to-block latency is one cycle after the 4th word transfer.
REQ-024 SHALL sustain one word per cycle within a block; arbitration costs one IDLE cycle per block.

Reset
REQ-025 SHALL, on rst high at any clock edge (including mid-block or in PAD), enter IDLE, clear counter, round-robin pointer to 0, tag FIFO empty, and reset the builder, discarding partial blocks.
REQ-026 SHALL drive req_ready = 0, block_valid = 0, block_owner = 0, block_last = 0 while in reset and on the first cycle after.

Structure
REQ-027 SHALL place FSM state encoding, word/block widths (32, 128) and words-per-block (4) in the shared crypto package.
REQ-028 SHALL instantiate exactly one be_block_builder sub-module as the word-to-block datapath.

Verification
REQ-029 Single requester: req0 sends 01234567, 89ABCDEF, A0A0A0A0, F9F9F9F9 back-to-back, block_ready=1 -> block 0123456789ABCDEFA0A0A0A0F9F9F9F9, owner 0, last 0.
REQ-030 Padding: req1 sends 11111111, 22222222 with last on second -> two PAD cycles, block 11111111222222220000000000000000, owner 1, last 1.
REQ-031 Fairness: both requesters continuously valid, 3 blocks each -> owners alternate 0,1,0,1,0,1; no block mixes words.
REQ-032 Backpressure: block_ready=0 while 8 words offered by req0 -> req_ready drops after 8th word, FIFO holds 2 tags; release -> both blocks delivered in order with correct tags.
REQ-033 Reset mid-block: rst after 2 words of req0 -> no block emitted; subsequent 4 words from req1 yield owner 1 block with only req1 data.
REQ-034 Last on 4th word: req0 last on word 4 -> no PAD, block_last 1, FSM back in IDLE next cycle.
